// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DIGIT_W     = 4;
  localparam int N_DIGITS    = 3;
  localparam int ADD3_THRESH = 5;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake plus result bus between the game FSM and the converter.
interface bin2bcd_seq_if #(
  parameter int IN_W = 8
) ();
  import bin2bcd_seq_pkg::*;

  logic               start;
  logic [IN_W-1:0]    bin_in;
  logic               busy;
  logic               done;
  logic [DIGIT_W-1:0] bcd_hundreds;
  logic [DIGIT_W-1:0] bcd_tens;
  logic [DIGIT_W-1:0] bcd_units;
  logic               ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_hundreds, bcd_tens, bcd_units, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_hundreds, bcd_tens, bcd_units, ovf
  );

endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Per-digit double-dabble correction: digits of 5 or more get +3 before the shift,
// so the shifted digit carries into the next decade. Max result is 12, fits 4 bits.
module bcd_add3_digit
  import bin2bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  // Conditional add-3 on a single BCD digit
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= DIGIT_W'(ADD3_THRESH)) begin
      digit_out = digit_in + DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; results hold the last completed value
//   SHIFT | converting; one correction+shift per edge, IN_W edges total
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  bin2bcd_seq_if.slave bus
);

  localparam int SCR_W = DIGIT_W * N_DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int CAT_W = SCR_W + IN_W;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IN_W-1:0]    bin_q, bin_d;
  logic [SCR_W-1:0]   scr_q, scr_d;
  logic [SCR_W-1:0]   res_q, res_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [SCR_W-1:0]   scr_adj;
  logic [CAT_W-1:0]   shifted;

  // Correction stage: one add-3 cell per BCD digit of the scratch register
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_in  (scr_q[g*DIGIT_W +: DIGIT_W]),
      .digit_out (scr_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Corrected scratch and remaining binary bits move left together
  assign shifted = {scr_adj, bin_q} << 1;

  // State, datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update; results only move on the final shift
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d   = bus.bin_in;
          scr_d   = '0;
          cnt_d   = CNT_W'(IN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = shifted[CAT_W-1 -: SCR_W];
        bin_d = shifted[IN_W-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          res_d   = shifted[CAT_W-1 -: SCR_W];
          ovf_d   = (shifted[CAT_W-1 -: DIGIT_W] != '0);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy         = (state_q == SHIFT);
  assign bus.done         = done_q;
  assign bus.bcd_hundreds = res_q[2*DIGIT_W +: DIGIT_W];
  assign bus.bcd_tens     = res_q[1*DIGIT_W +: DIGIT_W];
  assign bus.bcd_units    = res_q[0 +: DIGIT_W];
  assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: arithmetic reference model compared every
// cycle, plus directed scenarios with literal expected digits.
module tb_bin2bcd_seq;

  localparam int IN_W = 8;

  logic clk = 1'b0;
  logic rst;

  bin2bcd_seq_if #(.IN_W(IN_W)) bus ();

  bin2bcd_seq #(.IN_W(IN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a conversion takes IN_W edges, then digits come from plain division
  int       m_cnt  = 0;
  int       m_val  = 0;
  logic     m_done = 1'b0;
  logic [3:0] m_h = '0, m_t = '0, m_u = '0;
  logic     m_ovf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_h    <= '0;
      m_t    <= '0;
      m_u    <= '0;
      m_ovf  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_h    <= 4'(m_val / 100);
          m_t    <= 4'((m_val / 10) % 10);
          m_u    <= 4'(m_val % 10);
          m_ovf  <= (m_val > 99);
        end
      end else if (bus.start) begin
        m_val <= int'(bus.bin_in);
        m_cnt <= IN_W;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", int'(bus.busy), int'(m_cnt != 0));
      chk("cyc_done", int'(bus.done), int'(m_done));
      chk("cyc_hund", int'(bus.bcd_hundreds), int'(m_h));
      chk("cyc_tens", int'(bus.bcd_tens), int'(m_t));
      chk("cyc_units", int'(bus.bcd_units), int'(m_u));
      chk("cyc_ovf", int'(bus.ovf), int'(m_ovf));
      if (bus.done) n_done++;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 40) begin step(); n++; end
    if (bus.busy) begin errors++; checks++; $display("FAIL wait_idle: busy stuck at 1 expected 0"); end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 40) begin step(); n++; end
    if (!bus.done) begin
      errors++; checks++;
      $display("FAIL %s_timeout: done got 0 expected 1 within 40 cycles", name);
    end
  endtask

  // Launch one conversion, measure busy length, check literal digits
  task automatic convert(input string name, input int v, input int eh, input int et,
                         input int eu, input int eo);
    int blen = 0;
    int n = 0;
    wait_idle();
    bus.start = 1'b1; bus.bin_in = IN_W'(v);
    step();
    bus.start = 1'b0;
    while (!bus.done && n < 40) begin
      if (bus.busy) blen++;
      step(); n++;
    end
    chk({name, "_done"}, int'(bus.done), 1);
    chk({name, "_busylen"}, blen, IN_W);
    chk({name, "_hund"}, int'(bus.bcd_hundreds), eh);
    chk({name, "_tens"}, int'(bus.bcd_tens), et);
    chk({name, "_units"}, int'(bus.bcd_units), eu);
    chk({name, "_ovf"}, int'(bus.ovf), eo);
    step();
  endtask

  initial begin
    int d0, blen, n;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.bin_in = '0;
    @(posedge clk);
    cmp_en = 1'b1;
    step(); step();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_digits", int'({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_units}), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    rst = 1'b0;
    step();

    // Test 1: basic conversion
    convert("t1_30", 30, 0, 3, 0, 0);

    // Test 3: boundaries
    convert("b_0", 0, 0, 0, 0, 0);
    convert("b_99", 99, 0, 9, 9, 0);
    convert("b_100", 100, 1, 0, 0, 1);
    convert("b_255", 255, 2, 5, 5, 1);

    // Test 2: exhaustive sweep, next start issued in each done cycle
    wait_idle();
    d0 = n_done;
    bus.start = 1'b1; bus.bin_in = '0;
    step();
    bus.start = 1'b0;
    for (int v = 1; v < 256; v++) begin
      wait_done("sweep");
      bus.start = 1'b1; bus.bin_in = IN_W'(v);
      step();
      bus.start = 1'b0;
    end
    wait_done("sweep_last");
    step();
    chk("sweep_done_count", n_done - d0, 256);
    chk("sweep_last_hund", int'(bus.bcd_hundreds), 2);
    chk("sweep_last_units", int'(bus.bcd_units), 5);

    // Test 4: start during busy is ignored
    wait_idle();
    d0 = n_done;
    blen = 0;
    bus.start = 1'b1; bus.bin_in = IN_W'(50);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin if (bus.busy) blen++; step(); end
    bus.start = 1'b1; bus.bin_in = IN_W'(77);
    if (bus.busy) blen++;
    step();
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin if (bus.busy) blen++; step(); n++; end
    chk("ign_busylen", blen, IN_W);
    chk("ign_tens", int'(bus.bcd_tens), 5);
    chk("ign_units", int'(bus.bcd_units), 0);
    for (int i = 0; i < 12; i++) step();
    chk("ign_done_count", n_done - d0, 1);
    chk("ign_idle", int'(bus.busy), 0);

    // Test 5: reset mid-conversion
    wait_idle();
    d0 = n_done;
    bus.start = 1'b1; bus.bin_in = IN_W'(200);
    step();
    bus.start = 1'b0;
    step(); step(); step();
    chk("abort_busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_digits", int'({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_units}), 0);
    chk("abort_ovf", int'(bus.ovf), 0);
    for (int i = 0; i < 12; i++) step();
    chk("abort_no_done", n_done - d0, 0);
    convert("abort_45", 45, 0, 4, 5, 0);

    // Test 6: reset wins over start
    d0 = n_done;
    rst = 1'b1; bus.start = 1'b1; bus.bin_in = IN_W'(123);
    step();
    rst = 1'b0; bus.start = 1'b0;
    chk("rs_busy", int'(bus.busy), 0);
    for (int i = 0; i < 10; i++) step();
    chk("rs_busy_later", int'(bus.busy), 0);
    chk("rs_no_done", n_done - d0, 0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Iterative shift-and-add-3 (double-dabble) binary-to-BCD converter feeding the bcd_tens/bcd_units outputs of ell201_project.
Takes the 8-bit sum or score produced by the game core and converts it to hundreds/tens/units nibbles, one bit per clock.
Start/busy/done handshake, so the game FSM can launch a conversion and latch the result.
Flags values above 99, because the board shows only two BCD digits.

Parameters:
IN_W, 8, binary input width; legal range 1..9 so the result fits in three BCD digits.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request a conversion; sampled only when busy=0
bin_in  input  IN_W  unsigned binary value; sampled on the edge that accepts start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; result outputs valid and updated this cycle
bcd_hundreds  output  4  hundreds digit of the last completed conversion
bcd_tens  output  4  tens digit of the last completed conversion
bcd_units  output  4  units digit of the last completed conversion
ovf  output  1  high when the last result is >99 (bcd_hundreds != 0)

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset forces state=IDLE, busy=0, done=0, all bcd digits=0, ovf=0, shift counter=0, scratch registers=0. Reset has priority over start in the same cycle.
- States:
  - IDLE: busy=0. start=1 loads bin_in into the binary shift register, clears the 12-bit BCD scratch, sets counter=IN_W, then moves to SHIFT.
  - SHIFT: busy=1. Each edge, first add 3 to every scratch digit >=5, then shift {scratch, binreg} left by one. Counter decrements by one.
  - On the edge that performs the final (IN_W-th) shift: write the post-shift scratch to bcd_hundreds/tens/units, set ovf=(hundreds!=0), set done=1 for one cycle, return to IDLE.
- Latency: start accepted at edge 0; shifts occur on edges 1..IN_W. done and new outputs appear after edge IN_W, so busy is high for exactly IN_W cycles. IN_W=8 gives 8 cycles.
- done is high only in the cycle after the final-shift edge. It is a registered output with no combinational path from start.
- start while busy=1 is ignored: no queueing, no restart, no effect on the running result.
- bin_in changes while busy=1 have no effect; the value is captured at acceptance only.
- start=1 in the same cycle as done=1 is legal, because state is IDLE. The new conversion begins and the outputs hold the just-finished result until its own done.
- Result outputs hold their value between conversions. They change only on a done edge or on reset.
- Reset mid-conversion aborts the conversion: no done pulse, and all outputs are cleared to 0.
- Add-3 correction operates per 4-bit digit with no carry between digits. The correction result is always <=12, so no digit ever overflows 4 bits.
- Boundaries:
  - bin_in=0 gives 0/0/0, ovf=0.
  - 99 gives 0/9/9, ovf=0.
  - 100 gives 1/0/0, ovf=1.
  - 255 gives 2/5/5, ovf=1.
  - With IN_W=9, 511 gives 5/1/1.

Decomposition:
- Shared package holds:
  - state enum IDLE/SHIFT (1-bit encoding)
  - DIGIT_W=4
  - N_DIGITS=3
  - ADD3_THRESH=5
- One natural sub-module: bcd_add3_digit. It is combinational: 4-bit in, 4-bit out, out = in>=5 ? in+3 : in. It is instantiated N_DIGITS times inside the SHIFT datapath.
- Counter width is clog2(IN_W+1).

Test Plan:
1. Reset held 2 cycles, then start with bin_in=30 -> busy high exactly 8 cycles; done pulses once; digits 0/3/0; ovf=0.
2. Exhaustive sweep 0..255 with back-to-back start asserted in each done cycle -> each result matches v/100, (v/10)%10, v%10; ovf=(v>99); no lost or duplicate done.
3. Boundary values 99, 100, 255 -> 0/9/9 ovf=0, 1/0/0 ovf=1, 2/5/5 ovf=1.
4. start bin_in=50, then 3 cycles later start=1 with bin_in=77 during busy -> single done, result 0/5/0, busy length unchanged.
5. start bin_in=200, rst=1 on the 4th busy cycle -> no done; busy=0 and all digits=0 on the next cycle; a following start with bin_in=45 gives 0/4/5.
6. rst=1 and start=1 in the same cycle -> stays IDLE, busy=0, no done.
